systolic_mac_pe: RTL and testbench

Parametrised signed multiply-accumulate processing element for the systolic-array MLP datapath. It accumulates a dot product of streamed operand pairs into a wide accumulator and presents the finished sum through a valid/ready handshake. It forwards both operands one cycle later to the east/south neighbours. It is the next-generation tile cell: generic operand and accumulator widths, dot-product framing, backpressure and optional saturation.

---
 rtl/systolic_mac_pe_if.sv | 28 ++
 rtl/systolic_mac_pe.sv | 67 ++++++
 tb/tb_systolic_mac_pe.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_mac_pe_if.sv
// systolic_mac_pe_if: operand stream, neighbour forwarding and result handshake bundle for one MAC PE.
interface systolic_mac_pe_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
);
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic fwd_valid;
  logic result_valid;
  logic result_ready;
  logic ovf;
  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic [DATA_WIDTH-1:0] a_out;
  logic [DATA_WIDTH-1:0] b_out;
  logic [ACC_WIDTH-1:0] result;
  logic [CNT_WIDTH-1:0] result_count;
  modport master(
    output in_valid, in_last, a_in, b_in, result_ready,
    input in_ready, a_out, b_out, fwd_valid, result, result_count, result_valid, ovf
  );
  modport slave(
    input in_valid, in_last, a_in, b_in, result_ready,
    output in_ready, a_out, b_out, fwd_valid, result, result_count, result_valid, ovf
  );
endinterface

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: signed dot-product MAC PE with result handshake and east/south operand forwarding.
// Define SYSTOLIC_MAC_SATURATE_EN to clamp the accumulator (and flag ovf) instead of wrapping.
module systolic_mac_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  systolic_mac_pe_if.slave bus
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cntNext;
  logic ovfAcc;
  logic clamp;
  logic accept;
  logic signed [2*DATA_WIDTH-1:0] prod;
  assign prod = $signed(bus.a_in) * $signed(bus.b_in);
  assign accept = bus.in_valid && state == ACC;
  assign cntNext = &cnt ? cnt : cnt + 1'b1;
  assign bus.in_ready = state == ACC;
  assign bus.result_valid = state == HOLD;
`ifdef SYSTOLIC_MAC_SATURATE_EN
  // One guard bit exposes overflow: the top two bits disagree exactly when the true sum left the range.
  logic signed [ACC_WIDTH:0] wide;
  assign wide = $signed({acc[ACC_WIDTH-1], acc}) + (ACC_WIDTH+1)'(prod);
  assign clamp = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
  assign sum = !clamp ? wide[ACC_WIDTH-1:0] :
               wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
  assign clamp = 1'b0;
  assign sum = acc + ACC_WIDTH'(prod);
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ACC;
      acc <= '0;
      cnt <= '0;
      ovfAcc <= 1'b0;
      bus.a_out <= '0;
      bus.b_out <= '0;
      bus.fwd_valid <= 1'b0;
      bus.result <= '0;
      bus.result_count <= '0;
      bus.ovf <= 1'b0;
    end else begin
      bus.fwd_valid <= accept;
      if (accept) begin
        bus.a_out <= bus.a_in;
        bus.b_out <= bus.b_in;
        acc <= bus.in_last ? '0 : sum;
        cnt <= bus.in_last ? '0 : cntNext;
        ovfAcc <= !bus.in_last && (ovfAcc || clamp);
        if (bus.in_last) begin
          bus.result <= sum;
          bus.result_count <= cntNext;
          bus.ovf <= ovfAcc || clamp;
          state <= HOLD;
        end
      end else if (state == HOLD && bus.result_ready)
        state <= ACC;
    end
endmodule

// File: tb/tb_systolic_mac_pe.sv
// tb_systolic_mac_pe: drives a 24-bit and a 16-bit accumulator PE with identical streams and checks both against an arithmetic model.
module tb_systolic_mac_pe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inValid = 1'b0;
  logic inLast = 1'b0;
  logic resultReady = 1'b0;
  logic signed [7:0] inA = '0;
  logic signed [7:0] inB = '0;
  int checks = 0;
  int errors = 0;
  longint mAcc24 = 0, mAcc16 = 0, expR24 = 0, expR16 = 0;
  bit mOvf24 = 0, mOvf16 = 0, expO24 = 0, expO16 = 0;
  int mCnt = 0, expCnt = 0;

  systolic_mac_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) bus();
  systolic_mac_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) bus16();

  assign bus.in_valid = inValid;
  assign bus.in_last = inLast;
  assign bus.a_in = inA;
  assign bus.b_in = inB;
  assign bus.result_ready = resultReady;
  assign bus16.in_valid = inValid;
  assign bus16.in_last = inLast;
  assign bus16.a_in = inA;
  assign bus16.b_in = inB;
  assign bus16.result_ready = resultReady;

  systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  always #5 clk = ~clk;

  // Adds a product to a w-bit signed accumulator: clamps when saturation is built in, otherwise wraps mod 2^w.
  function automatic longint step(input longint acc, input longint p, input int w, output bit o);
    longint s = acc + p;
    longint m = longint'(1) << w;
    longint mx = (longint'(1) << (w - 1)) - 1;
    longint mn = -mx - 1;
`ifdef SYSTOLIC_MAC_SATURATE_EN
    o = (s > mx) || (s < mn);
    return s > mx ? mx : (s < mn ? mn : s);
`else
    o = 1'b0;
    s = ((s % m) + m) % m;
    return s > mx ? s - m : s;
`endif
  endfunction

  task automatic model_clear();
    mAcc24 = 0;
    mAcc16 = 0;
    mOvf24 = 0;
    mOvf16 = 0;
    mCnt = 0;
  endtask

  task automatic send(input logic signed [7:0] a, input logic signed [7:0] b, input bit last);
    bit ok;
    bit o;
    int n = 0;
    longint p;
    inA = a;
    inB = b;
    inLast = last;
    inValid = 1'b1;
    do begin
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    inValid = 1'b0;
    inLast = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
      return;
    end
    p = longint'(a) * longint'(b);
    mAcc24 = step(mAcc24, p, 24, o);
    mOvf24 |= o;
    mAcc16 = step(mAcc16, p, 16, o);
    mOvf16 |= o;
    mCnt = mCnt < 255 ? mCnt + 1 : 255;
    if (last) begin
      expR24 = mAcc24;
      expR16 = mAcc16;
      expO24 = mOvf24;
      expO16 = mOvf16;
      expCnt = mCnt;
      model_clear();
    end
    checks++;
    if ({bus.fwd_valid, bus.a_out, bus.b_out, bus16.fwd_valid, bus16.a_out, bus16.b_out} !== {1'b1, a, b, 1'b1, a, b}) begin
      errors++;
      $display("FAIL forward: fwd_valid=%0b a_out=%0d b_out=%0d, required 1 %0d %0d",
               bus.fwd_valid, $signed(bus.a_out), $signed(bus.b_out), a, b);
    end
  endtask

  task automatic check_result(input string tag);
    checks++;
    if (bus.result_valid !== 1'b1 || bus16.result_valid !== 1'b1 ||
        longint'($signed(bus.result)) !== expR24 || longint'($signed(bus16.result)) !== expR16 ||
        int'(bus.result_count) !== expCnt || int'(bus16.result_count) !== expCnt ||
        bus.ovf !== expO24 || bus16.ovf !== expO16) begin
      errors++;
      $display("FAIL %s: valid=%0b/%0b result=%0d/%0d count=%0d/%0d ovf=%0b/%0b, required 1 %0d/%0d %0d %0b/%0b",
               tag, bus.result_valid, bus16.result_valid, $signed(bus.result), $signed(bus16.result),
               bus.result_count, bus16.result_count, bus.ovf, bus16.ovf, expR24, expR16, expCnt, expO24, expO16);
    end
  endtask

  // Called right after the in_last beat; holds result_ready low for `hold` cycles while offering beats.
  task automatic collect(input int hold);
    check_result("result");
    for (int i = 0; i < hold; i++) begin
      inValid = 1'b1;
      inLast = 1'($urandom);
      inA = 8'($urandom);
      inB = 8'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.fwd_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_stall: in_ready=%0b fwd_valid=%0b, required 0 0", bus.in_ready, bus.fwd_valid);
      end
      check_result("hold_stable");
    end
    inValid = 1'b0;
    inLast = 1'b0;
    resultReady = 1'b1;
    @(posedge clk);
    #1;
    resultReady = 1'b0;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: result_valid=%0b in_ready=%0b, required 0 1", bus.result_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({bus.in_ready, bus.a_out, bus.b_out, bus.fwd_valid, bus.result, bus.result_count, bus.result_valid, bus.ovf} !==
        {1'b1, 8'd0, 8'd0, 1'b0, 24'd0, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: in_ready=%0b a_out=%0d b_out=%0d fwd=%0b result=%0d count=%0d valid=%0b ovf=%0b, required 1 0 0 0 0 0 0 0",
               bus.in_ready, bus.a_out, bus.b_out, bus.fwd_valid, bus.result, bus.result_count, bus.result_valid, bus.ovf);
    end
  endtask

  task automatic test_basic();
    send(3, 4, 0);
    send(-2, 5, 0);
    send(7, -1, 0);
    send(1, 1, 1);
    collect(5);
  endtask

  task automatic test_forward();
    send(10, 1, 0);
    send(20, 2, 0);
    send(30, 3, 0);
    @(posedge clk);
    #1;
    checks++;
    if (bus.fwd_valid !== 1'b0 || bus.a_out !== 8'd30 || bus.b_out !== 8'd3) begin
      errors++;
      $display("FAIL forward_idle: fwd_valid=%0b a_out=%0d b_out=%0d, required 0 30 3", bus.fwd_valid, bus.a_out, bus.b_out);
    end
    send(0, 0, 1);
    collect(0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) send(127, 127, i == 3);
    collect(1);
    for (int i = 0; i < 3; i++) send(-128, 127, i == 2);
    collect(0);
  endtask

  task automatic test_reset_mid();
    send(5, 5, 0);
    send(6, 6, 0);
    #3;
    reset = 1'b1;
    model_clear();
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.result_valid !== 1'b0 || bus.fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: in_ready=%0b result_valid=%0b fwd_valid=%0b, required 1 0 0", bus.in_ready, bus.result_valid, bus.fwd_valid);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(2, 3, 1);
    collect(1);
    send(1, 1, 1);
    check_result("pre_reset_hold");
    reset = 1'b1;
    #2;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.result !== 24'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_hold: result_valid=%0b result=%0d in_ready=%0b, required 0 0 1", bus.result_valid, bus.result, bus.in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int d = 0; d < 12; d++) begin
      int len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        logic signed [7:0] a, b;
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          resultReady = 1'($urandom);
          @(posedge clk);
          #1;
          resultReady = 1'b0;
        end
        a = $urandom_range(0, 2) == 0 ? ($urandom_range(0, 1) ? 8'sd127 : -8'sd128) : 8'($urandom);
        b = $urandom_range(0, 2) == 0 ? ($urandom_range(0, 1) ? 8'sd127 : -8'sd128) : 8'($urandom);
        send(a, b, k == len - 1);
      end
      collect($urandom_range(0, 3));
    end
  endtask

  task automatic test_count_sat();
    for (int i = 0; i < 300; i++) send(1, 1, i == 299);
    collect(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward();
    test_saturation();
    test_reset_mid();
    test_random();
    test_count_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
